// File: rtl/canny_pkg.sv
// Shared types and gradient helpers for the canny edge pipeline.
// sobel_mag is sized for the widest supported pixel so later stages can reuse it.
package canny_pkg;

    typedef enum logic {SOBEL_MAG, SOBEL_BIN} sobel_mode_e;

    localparam int GRAD_EXTRA_W = 3;
    localparam int SOBEL_MAX_W  = 16;
    localparam int SOBEL_GRAD_W = SOBEL_MAX_W + GRAD_EXTRA_W;

    typedef logic [2:0][2:0][SOBEL_MAX_W-1:0] sobel_win_t;
    typedef logic [SOBEL_GRAD_W-1:0] sobel_grad_t;

    function automatic sobel_grad_t sobel_ext(input logic [SOBEL_MAX_W-1:0] p);
        return {{GRAD_EXTRA_W{1'b0}}, p};
    endfunction

    function automatic sobel_grad_t sobel_abs(input sobel_grad_t g);
        return g[SOBEL_GRAD_W-1] ? (~g + sobel_grad_t'(1)) : g;
    endfunction

    // w[row][col]; positive and negative taps summed separately, then
    // the difference is read as two's complement.
    function automatic sobel_grad_t sobel_mag(input sobel_win_t w);
        sobel_grad_t xp;
        sobel_grad_t xn;
        sobel_grad_t yp;
        sobel_grad_t yn;
        xp = sobel_ext(w[0][2]) + (sobel_ext(w[1][2]) << 1) + sobel_ext(w[2][2]);
        xn = sobel_ext(w[0][0]) + (sobel_ext(w[1][0]) << 1) + sobel_ext(w[2][0]);
        yp = sobel_ext(w[2][0]) + (sobel_ext(w[2][1]) << 1) + sobel_ext(w[2][2]);
        yn = sobel_ext(w[0][0]) + (sobel_ext(w[0][1]) << 1) + sobel_ext(w[0][2]);
        return sobel_abs(xp - xn) + sobel_abs(yp - yn);
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One-line delay: read-before-write at a rotating address.
// dout is the value written DEPTH accepts ago.
module line_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 640
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     ptr;

    assign dout = mem[ptr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + AW'(1);
        end
    end

endmodule

// File: rtl/sobel_edge_stream.sv
// Streaming 3x3 Sobel stage: raster pixels in, interior gradient or edge map out.
// Window and line buffers advance only on accepted input pixels.
module sobel_edge_stream
    import canny_pkg::*;
#(
    parameter int PIXEL_W = 8,
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PIXEL_W-1:0] pixel_in,
    input  logic               pixel_in_valid,
    output logic               in_ready,
    input  logic               mode,
    input  logic [PIXEL_W+2:0] thresh,
    output logic [PIXEL_W-1:0] pixel_out,
    output logic               pixel_out_valid,
    output logic               pixel_out_last,
    input  logic               out_ready
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam sobel_grad_t   PIX_MAX  = sobel_grad_t'({PIXEL_W{1'b1}});

    logic [CW-1:0]      col;
    logic [RW-1:0]      row;
    logic               accept;
    logic               emit;
    logic               at_last;
    logic [PIXEL_W-1:0] lb0_q;
    logic [PIXEL_W-1:0] lb1_q;
    logic [PIXEL_W-1:0] win [3][3];
    logic [PIXEL_W-1:0] col_in [3];
    sobel_win_t         next_win;
    sobel_grad_t        grad;
    sobel_mode_e        frame_mode;
    logic [PIXEL_W+2:0] frame_thresh;
    logic [PIXEL_W-1:0] result;

    assign in_ready = !pixel_out_valid || out_ready;
    assign accept   = pixel_in_valid && in_ready;
    assign emit     = accept && (row >= RW'(2)) && (col >= CW'(2));
    assign at_last  = (row == ROW_LAST) && (col == COL_LAST);

    line_buffer #(.DATA_W(PIXEL_W), .DEPTH(IMG_W)) u_lb0 (
        .clk  (clk),
        .rst  (rst),
        .en   (accept),
        .din  (pixel_in),
        .dout (lb0_q)
    );

    line_buffer #(.DATA_W(PIXEL_W), .DEPTH(IMG_W)) u_lb1 (
        .clk  (clk),
        .rst  (rst),
        .en   (accept),
        .din  (lb0_q),
        .dout (lb1_q)
    );

    // Incoming column: oldest row on top, current pixel at the bottom.
    always_comb begin
        col_in[0] = lb1_q;
        col_in[1] = lb0_q;
        col_in[2] = pixel_in;
    end

    always_comb begin
        next_win = '0;
        for (int i = 0; i < 3; i++) begin
            next_win[i][0] = SOBEL_MAX_W'(win[i][1]);
            next_win[i][1] = SOBEL_MAX_W'(win[i][2]);
            next_win[i][2] = SOBEL_MAX_W'(col_in[i]);
        end
    end

    assign grad = sobel_mag(next_win);

    always_comb begin
        result = '0;
        if (frame_mode == SOBEL_BIN) begin
            result = (grad >= sobel_grad_t'(frame_thresh)) ? '1 : '0;
        end else begin
            result = (grad > PIX_MAX) ? '1 : grad[PIXEL_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
                win[i][2] <= col_in[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_mode   <= SOBEL_MAG;
            frame_thresh <= '0;
        end else if (accept && row == '0 && col == '0) begin
            frame_mode   <= sobel_mode_e'(mode);
            frame_thresh <= thresh;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_out       <= '0;
            pixel_out_valid <= 1'b0;
            pixel_out_last  <= 1'b0;
        end else if (emit) begin
            pixel_out       <= result;
            pixel_out_valid <= 1'b1;
            pixel_out_last  <= at_last;
        end else if (out_ready) begin
            pixel_out_valid <= 1'b0;
            pixel_out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sobel_edge_stream.sv
// Directed bench for sobel_edge_stream on an 8x6 frame (24 interior outputs).
// Outputs are collected on the falling edge and compared to hand-derived patterns.
module tb_sobel_edge_stream;

    localparam int PW   = 8;
    localparam int W    = 8;
    localparam int H    = 6;
    localparam int NOUT = (W - 2) * (H - 2);

    localparam int K_FLAT = 0;
    localparam int K_STEP = 1;
    localparam int K_RAMP = 2;

    localparam int E_ZERO = 0;
    localparam int E_STEP = 1;
    localparam int E_ONES = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] pixel_in = '0;
    logic          pixel_in_valid = 1'b0;
    logic          in_ready;
    logic          mode = 1'b0;
    logic [PW+2:0] thresh = '0;
    logic [PW-1:0] pixel_out;
    logic          pixel_out_valid;
    logic          pixel_out_last;
    logic          out_ready = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int stalls   = 0;
    int or_mode  = 0;
    int out_q[$];
    int last_q[$];
    logic          pend = 1'b0;
    logic [PW-1:0] held = '0;

    always #5 clk = ~clk;

    sobel_edge_stream #(.PIXEL_W(PW), .IMG_W(W), .IMG_H(H)) dut (
        .clk             (clk),
        .rst             (rst),
        .pixel_in        (pixel_in),
        .pixel_in_valid  (pixel_in_valid),
        .in_ready        (in_ready),
        .mode            (mode),
        .thresh          (thresh),
        .pixel_out       (pixel_out),
        .pixel_out_valid (pixel_out_valid),
        .pixel_out_last  (pixel_out_last),
        .out_ready       (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        #2;
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                check("stall_valid", 32'(pixel_out_valid), 1);
                check("stall_data", 32'(pixel_out), 32'(held));
            end
            if (pixel_out_valid && out_ready) begin
                out_q.push_back(int'(pixel_out));
                last_q.push_back(int'(pixel_out_last));
                pend = 1'b0;
            end else if (pixel_out_valid) begin
                pend = 1'b1;
                held = pixel_out;
            end else begin
                pend = 1'b0;
            end
        end
    end

    function automatic logic [PW-1:0] pix(input int kind, input int c);
        case (kind)
            K_FLAT:  return 8'd50;
            K_STEP:  return (c < 4) ? 8'd0 : 8'd100;
            default: return 8'(10 * c);
        endcase
    endfunction

    function automatic int expect_px(input int ek, input int i);
        int cc;
        cc = i % (W - 2) + 1;
        case (ek)
            E_STEP:  return (cc == 3 || cc == 4) ? 255 : 0;
            E_ONES:  return 255;
            default: return 0;
        endcase
    endfunction

    task automatic send_pixel(input logic [PW-1:0] p);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        pixel_in       = p;
        pixel_in_valid = 1'b1;
        while (!acc && n < 1000) begin
            @(negedge clk);
            acc = in_ready;
            if (!acc) stalls++;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic send_pixels(input int kind, input int first, input int cnt);
        for (int k = first; k < first + cnt; k++) begin
            send_pixel(pix(kind, k % W));
        end
    endtask

    task automatic drain_check(input string tag, input int ek);
        int t;
        t = 0;
        pixel_in_valid = 1'b0;
        while ((out_q.size() < NOUT || pixel_out_valid) && t < 400) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        check({tag, "_count"}, 32'(out_q.size()), NOUT);
        for (int i = 0; i < out_q.size() && i < NOUT; i++) begin
            check($sformatf("%s_px%0d", tag, i), 32'(out_q[i]), 32'(expect_px(ek, i)));
            check($sformatf("%s_last%0d", tag, i), 32'(last_q[i]),
                  (i == NOUT - 1) ? 32'd1 : 32'd0);
        end
        out_q.delete();
        last_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(pixel_out_valid), 0);
        check("rst_last", 32'(pixel_out_last), 0);
        check("rst_data", 32'(pixel_out), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;

        mode   = 1'b0;
        thresh = '0;
        stalls = 0;
        send_pixels(K_FLAT, 0, W * H);
        check("t1_in_ready_stalls", 32'(stalls), 0);
        drain_check("t1_flat", E_ZERO);

        send_pixels(K_STEP, 0, W * H);
        drain_check("t2_step", E_STEP);

        mode   = 1'b1;
        thresh = 11'd80;
        send_pixels(K_RAMP, 0, W * H);
        drain_check("t3_ramp80", E_ONES);
        thresh = 11'd81;
        send_pixels(K_RAMP, 0, W * H);
        drain_check("t3_ramp81", E_ZERO);

        mode    = 1'b0;
        or_mode = 1;
        send_pixels(K_STEP, 0, W * H);
        drain_check("t4_stall", E_STEP);
        or_mode = 0;
        @(posedge clk);
        #1;

        send_pixels(K_STEP, 0, 20);
        pixel_in_valid = 1'b0;
        or_mode = 2;
        rst     = 1'b1;
        @(negedge clk);
        check("t5_pending_before_rst", 32'(pixel_out_valid), 1);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        or_mode = 0;
        @(negedge clk);
        check("t5_valid_after_rst", 32'(pixel_out_valid), 0);
        @(posedge clk);
        #1;
        out_q.delete();
        last_q.delete();
        send_pixels(K_FLAT, 0, W * H);
        drain_check("t5_flat", E_ZERO);

        mode   = 1'b0;
        thresh = 11'd500;
        send_pixels(K_STEP, 0, 20);
        mode = 1'b1;
        send_pixels(K_STEP, 20, W * H - 20);
        drain_check("t6_mag_frame", E_STEP);
        send_pixels(K_STEP, 0, W * H);
        drain_check("t6_bin_frame", E_ZERO);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
